// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 LSB-first serial receiver with centre sampling, a frame-error strobe and a break lock-out
// Ports: clk, rst (sync, active-high); rx (async serial line, idle high);
//        data_out (last good byte), valid / frame_err (one-cycle strobes), busy (not in IDLE)
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d, data_q, data_d;
   logic          valid_q, valid_d, ferr_q, ferr_d;
   logic          rx_meta_q, rx_s_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            state_d = rx_s_q ? IDLE : START;
         end
         START: if (cnt_q == HALF) begin
            // start bit re-checked at its centre; a high line here was only a glitch
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
         end
         DATA: if (cnt_q == FULL) begin
            cnt_d   = '0;
            sh_d    = {rx_s_q, sh_q[7:1]};
            idx_d   = idx_q + 3'd1;
            state_d = (idx_q == 3'd7) ? STOP : DATA;
         end
         STOP: if (cnt_q == FULL) begin
            cnt_d   = '0;
            data_d  = rx_s_q ? sh_q : data_q;
            valid_d = rx_s_q;
            ferr_d  = !rx_s_q;
            state_d = rx_s_q ? IDLE : BREAK;
         end
         BREAK: begin
            // a line held low must return high before another start edge counts
            cnt_d   = '0;
            state_d = rx_s_q ? IDLE : BREAK;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end
   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed self-checking bench for uart_rx_byte at 16 clocks/bit, plus a 17 clocks/bit instance with +/-2% rate offset
module tb_uart_rx_byte;
   logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx2 = 1'b1;
   logic [7:0] data_out, data_out2;
   logic       valid, frame_err, busy, valid2, frame_err2, busy2;
   int         cyc = 0, vcnt = 0, fcnt = 0, v2cnt = 0, f2cnt = 0, vcyc = 0, bad = 0;
   int         n_chk = 0, n_pass = 0, t0 = 0, v0 = 0, f0 = 0, qb = 0;
   logic       pv = 1'b0, pf = 1'b0, pv2 = 1'b0, pf2 = 1'b0;
   logic [7:0] vq[$];

   uart_rx_byte #(.CLKS_PER_BIT(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
      .valid(valid), .frame_err(frame_err), .busy(busy)
   );
   uart_rx_byte #(.CLKS_PER_BIT(17)) dut2 (
      .clk(clk), .rst(rst), .rx(rx2), .data_out(data_out2),
      .valid(valid2), .frame_err(frame_err2), .busy(busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         vcnt <= vcnt + 1;
         vcyc <= cyc;
         vq.push_back(data_out);
      end
      if (frame_err) fcnt <= fcnt + 1;
      if (valid2) v2cnt <= v2cnt + 1;
      if (frame_err2) f2cnt <= f2cnt + 1;
      if ((valid && frame_err) || (valid && pv) || (frame_err && pf) ||
          (valid2 && frame_err2) || (valid2 && pv2) || (frame_err2 && pf2))
         bad <= bad + 1;
      pv  <= valid;
      pf  <= frame_err;
      pv2 <= valid2;
      pf2 <= frame_err2;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // bit k spans [k*cpb*pct/100, (k+1)*cpb*pct/100) cycles; line is left at the stop-bit level
   task automatic send(input bit ln, input logic [7:0] b, input logic sb, input int cpb, input int pct);
      logic [9:0] f;
      f  = {sb, b, 1'b0};
      t0 = cyc;
      for (int k = 0; k < 10; k++) begin
         if (ln) rx2 = f[k];
         else rx = f[k];
         repeat (((k + 1) * cpb * pct) / 100 - (k * cpb * pct) / 100) @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_data", data_out, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_busy2", busy2, 1'b0);

      // single byte, latency = 2 sync + 8 + 144 + 1
      v0 = vcnt; f0 = fcnt;
      send(0, 8'hA5, 1'b1, 16, 100);
      repeat (10) @(negedge clk);
      chk("a5_count", vcnt - v0, 1);
      chk("a5_data", data_out, 8'hA5);
      chk("a5_ferr", fcnt - f0, 0);
      chk("a5_latency", vcyc - t0, 155);

      // 4-cycle low glitch
      v0 = vcnt; f0 = fcnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      chk("glitch_busy_mid", busy, 1'b1);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      chk("glitch_busy_end", busy, 1'b0);
      repeat (20) @(negedge clk);
      chk("glitch_valid", vcnt - v0, 0);
      chk("glitch_ferr", fcnt - f0, 0);

      // bad stop bit then line held low (break)
      v0 = vcnt; f0 = fcnt;
      send(0, 8'h3C, 1'b0, 16, 100);
      repeat (40) @(negedge clk);
      chk("brk_ferr", fcnt - f0, 1);
      chk("brk_valid", vcnt - v0, 0);
      chk("brk_data", data_out, 8'hA5);
      chk("brk_busy", busy, 1'b1);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("brk_release", busy, 1'b0);
      chk("brk_ferr_once", fcnt - f0, 1);
      send(0, 8'h01, 1'b1, 16, 100);
      repeat (10) @(negedge clk);
      chk("brk_next_data", data_out, 8'h01);
      chk("brk_next_count", vcnt - v0, 1);

      // back-to-back frames
      v0 = vcnt; qb = vq.size();
      send(0, 8'h00, 1'b1, 16, 100);
      send(0, 8'hFF, 1'b1, 16, 100);
      send(0, 8'h5A, 1'b1, 16, 100);
      repeat (10) @(negedge clk);
      chk("b2b_count", vcnt - v0, 3);
      chk("b2b_0", vq[qb], 8'h00);
      chk("b2b_1", vq[qb+1], 8'hFF);
      chk("b2b_2", vq[qb+2], 8'h5A);

      // reset during data bits of 8'h77 (start, then bits 0..2 = 1)
      v0 = vcnt; f0 = fcnt;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (24) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_data", data_out, 8'h00);
      chk("abort_busy", busy, 1'b0);
      repeat (200) @(negedge clk);
      chk("abort_valid", vcnt - v0, 0);
      chk("abort_ferr", fcnt - f0, 0);
      send(0, 8'h12, 1'b1, 16, 100);
      repeat (10) @(negedge clk);
      chk("abort_next_data", data_out, 8'h12);
      chk("abort_next_count", vcnt - v0, 1);

      // 17 clocks/bit with line rate offset
      v0 = v2cnt; f0 = f2cnt;
      send(1, 8'hA5, 1'b1, 17, 102);
      repeat (10) @(negedge clk);
      chk("fast_count", v2cnt - v0, 1);
      chk("fast_data", data_out2, 8'hA5);
      send(1, 8'hC3, 1'b1, 17, 98);
      repeat (10) @(negedge clk);
      chk("slow_count", v2cnt - v0, 2);
      chk("slow_data", data_out2, 8'hC3);
      chk("offset_ferr", f2cnt - f0, 0);

      chk("strobe_rules", bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
